// File: rtl/uart_tx.sv
// uart_tx: serialises one DATA_W-bit word per valid/ready handshake as start, data LSB first, optional parity, stop bits.
module uart_tx #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              tx_busy,
  output logic              tx_uart
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt0_q, cnt0_d;
  logic [2:0]        cnt1_q, cnt1_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d, tx_q, tx_d, busy_q, busy_d, rdy_q, rdy_d;
  logic              accept, bit_end, last_data, last_stop;
  assign accept    = tx_vld && rdy_q;
  assign bit_end   = (state_q != IDLE) && (cnt0_q == CW'(BAUD_DIV - 1));
  assign last_data = cnt1_q == 3'(DATA_W - 1);
  assign last_stop = cnt1_q == 3'(STOP_BITS - 1);
  always_comb begin
    state_d = state_q;
    cnt1_d  = cnt1_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt0_d  = (state_q == IDLE || bit_end) ? '0 : cnt0_q + CW'(1);
    if (accept) begin
      state_d = START;
      shift_d = tx_data;
      par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
    end else if (bit_end) begin
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          cnt1_d  = last_data ? '0 : cnt1_q + 3'd1;
          state_d = !last_data ? DATA : (PARITY != 0) ? PAR : STOP;
        end
        PAR: state_d = STOP;
        STOP: begin
          cnt1_d  = last_stop ? '0 : cnt1_q + 3'd1;
          state_d = last_stop ? IDLE : STOP;
        end
        default: state_d = IDLE;
      endcase
    end
    // Line level is derived from the next state so tx_uart is a clean flop output.
    tx_d   = (state_d == START) ? 1'b0 :
             (state_d == DATA)  ? shift_d[0] :
             (state_d == PAR)   ? par_d : 1'b1;
    busy_d = state_d != IDLE;
    rdy_d  = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end
  assign tx_uart = tx_q;
  assign tx_busy = busy_q;
  assign tx_rdy  = rdy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame checks on four transmitter configurations using a vector table, an accept-time scoreboard and corner-case sequences.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vld = '0;
  logic [3:0] rdy, busy, line;
  logic [7:0] dat [4];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  typedef struct {int inst; logic [7:0] data; int nbits; logic [11:0] frame; int span;} vec_t;
  typedef struct {int inst; logic [11:0] frame;} sb_t;
  sb_t  sbq [$];
  vec_t tv [7];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx #(.BAUD_DIV(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_vld(vld[0]),
    .tx_rdy(rdy[0]), .tx_busy(busy[0]), .tx_uart(line[0]));
  uart_tx #(.BAUD_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) d1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_vld(vld[1]),
    .tx_rdy(rdy[1]), .tx_busy(busy[1]), .tx_uart(line[1]));
  uart_tx #(.BAUD_DIV(4), .DATA_W(8), .PARITY(1), .STOP_BITS(2)) d2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_vld(vld[2]),
    .tx_rdy(rdy[2]), .tx_busy(busy[2]), .tx_uart(line[2]));
  uart_tx #(.BAUD_DIV(5208), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) d3 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .tx_vld(vld[3]),
    .tx_rdy(rdy[3]), .tx_busy(busy[3]), .tx_uart(line[3]));
  // Reference frame, bit k is the k-th bit on the line.
  function automatic logic [11:0] model(input int i, input logic [7:0] d);
    int p = (i == 1) ? 2 : (i == 2) ? 1 : 0;
    int s = (i == 2) ? 2 : 1;
    int n = 9 + ((p != 0) ? 1 : 0) + s;
    logic [11:0] f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    if (p != 0) f[9] = (p == 1) ? ~^d : ^d;
    return f & ((12'd1 << n) - 12'd1);
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rst_n && vld[i] && rdy[i]) sbq.push_back('{i, model(i, dat[i])});
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask
  task automatic wait_low(input int i, input int limit, output int ok);
    ok = 0;
    for (int n = 0; n < limit; n++) begin
      if (line[i] === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic wait_rdy(input int i, input int limit, output int ok);
    ok = 0;
    for (int n = 0; n < limit; n++) begin
      if (rdy[i] === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask
  // Entered half a clock into the start bit; samples every bit at its centre.
  task automatic read_bits(input int i, input int div, input int n, output logic [11:0] b);
    b = '0;
    repeat (div / 2 - 1) @(negedge clk);
    b[0] = line[i];
    for (int k = 1; k < n; k++) begin
      repeat (div) @(negedge clk);
      b[k] = line[i];
    end
  endtask
  task automatic sb_pop(input int i, input logic [11:0] b, input string nm);
    sb_t e;
    if (sbq.size() == 0) check({nm, "_sb_empty"}, 0, 1);
    else begin
      e = sbq.pop_front();
      check({nm, "_sb_inst"}, e.inst, i);
      check({nm, "_sb_frame"}, b, e.frame);
    end
  endtask
  task automatic run_frame(input int i, input logic [7:0] d, input int div, input int n,
                           input logic [11:0] exp, input int span, input string nm);
    logic [11:0] b;
    int t0, ok;
    @(negedge clk);
    dat[i] = d;
    vld[i] = 1'b1;
    @(negedge clk);
    vld[i] = 1'b0;
    wait_low(i, 4, ok);
    check({nm, "_start"}, ok, 1);
    t0 = cyc;
    read_bits(i, div, n, b);
    check({nm, "_bits"}, b, exp);
    sb_pop(i, b, nm);
    wait_rdy(i, div * n + 50, ok);
    check({nm, "_idle_seen"}, ok, 1);
    check({nm, "_span"}, cyc - t0, span);
  endtask
  initial begin
    logic [11:0] b1, b2;
    int t1, t2, ok, bad;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    tv[0] = '{0, 8'h55, 10, 12'b001010101010, 40};
    tv[1] = '{0, 8'hFF, 10, 12'b001111111110, 40};
    tv[2] = '{0, 8'h81, 10, 12'b001100000010, 40};
    tv[3] = '{1, 8'h07, 11, 12'b011000001110, 44};
    tv[4] = '{1, 8'h00, 11, 12'b010000000000, 44};
    tv[5] = '{2, 8'h07, 12, 12'b110000001110, 48};
    tv[6] = '{2, 8'hFF, 12, 12'b111111111110, 48};
    repeat (3) @(negedge clk);
    check("reset_outputs", {line, rdy, busy}, {4'hF, 4'hF, 4'h0});
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (line !== 4'hF || rdy !== 4'hF || busy !== 4'h0) bad++;
    end
    check("idle_100", bad, 0);
    for (int v = 0; v < 7; v++)
      run_frame(tv[v].inst, tv[v].data, 4, tv[v].nbits, tv[v].frame, tv[v].span, $sformatf("vec%0d", v));
    // Back-to-back with tx_vld held; data changed right after the first accept.
    @(negedge clk);
    dat[0] = 8'hA5;
    vld[0] = 1'b1;
    @(negedge clk);
    dat[0] = 8'h3C;
    wait_low(0, 4, ok);
    check("b2b_start1", ok, 1);
    t1 = cyc;
    read_bits(0, 4, 10, b1);
    wait_low(0, 10, ok);
    check("b2b_start2", ok, 1);
    t2 = cyc;
    vld[0] = 1'b0;
    read_bits(0, 4, 10, b2);
    check("b2b_gap", t2 - t1, 41);
    check("b2b_bits1", b1, 12'b001101001010);
    check("b2b_bits2", b2, 12'b001001111000);
    sb_pop(0, b1, "b2b1");
    sb_pop(0, b2, "b2b2");
    wait_rdy(0, 20, ok);
    check("b2b_idle", ok, 1);
    // A tx_vld pulse in the middle of a frame must be ignored.
    @(negedge clk);
    dat[0] = 8'h00;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    wait_low(0, 4, ok);
    check("busy_start", ok, 1);
    fork
      begin
        repeat (6) @(negedge clk);
        dat[0] = 8'hFF;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
      end
    join_none
    read_bits(0, 4, 10, b1);
    check("busy_bits", b1, 12'b001000000000);
    sb_pop(0, b1, "busy");
    wait_rdy(0, 20, ok);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (line[0] !== 1'b1) bad++;
    end
    check("busy_no_frame", bad, 0);
    check("busy_sb_left", sbq.size(), 0);
    // Asynchronous reset during bit 3 of a frame.
    @(negedge clk);
    dat[0] = 8'h00;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    wait_low(0, 4, ok);
    check("rst_start", ok, 1);
    repeat (13) @(negedge clk);
    check("rst_pre_line", line[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async", {line[0], rdy[0], busy[0]}, 3'b110);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", {line[0], rdy[0], busy[0]}, 3'b110);
    run_frame(0, 8'h81, 4, 10, 12'b001100000010, 40, "post_rst");
    // Full-rate divider: span and loopback decode.
    run_frame(3, 8'h5A, 5208, 10, model(3, 8'h5A), 52080, "baud5208");
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
